// File: rtl/inert_pkg.sv
// Shared types and constants for the IMU interface: FSM states, the
// configuration write sequence and the read address range.
package inert_pkg;

    typedef enum logic [2:0] {
        PWR_UP,
        CFG_ISSUE,
        CFG_WAIT,
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        VALID
    } state_e;

    localparam logic [15:0] CFG_W0 = 16'h0D02;
    localparam logic [15:0] CFG_W1 = 16'h1062;
    localparam logic [15:0] CFG_W2 = 16'h1162;
    localparam logic [15:0] CFG_W3 = 16'h1460;

    localparam logic [7:0] RD_BASE  = 8'hA2;
    localparam logic [2:0] CFG_LAST = 3'd3;
    localparam logic [2:0] RD_LAST  = 3'd5;
    localparam int unsigned NUM_RD  = 6;

    function automatic logic [15:0] cfg_word(input logic [2:0] idx);
        logic [15:0] w;
        case (idx)
            3'd0:    w = CFG_W0;
            3'd1:    w = CFG_W1;
            3'd2:    w = CFG_W2;
            3'd3:    w = CFG_W3;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the asynchronous IMU interrupt into clk.
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/inert_intf.sv
// IMU interface: powers up, writes four config words over SPI, then on each
// data-ready interrupt reads six bytes and publishes pitch/roll/yaw together.
module inert_intf
    import inert_pkg::*;
#(
    parameter int unsigned PWR_UP_CLKS = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw,
    output logic        vld
);

    localparam logic [15:0] PWR_CNT = 16'(PWR_UP_CLKS);

    state_e          r_state, w_state_d;
    logic [15:0]     r_cnt, w_cnt_d;
    logic [2:0]      r_idx, w_idx_d;
    logic            r_wrt, w_wrt_d;
    logic [15:0]     r_cmd, w_cmd_d;
    logic [5:0][7:0] r_hold, w_hold_d;
    logic            r_done, w_done_d;
    logic [7:0]      r_byte, w_byte_d;
    logic [15:0]     r_ptch, w_ptch_d;
    logic [15:0]     r_roll, w_roll_d;
    logic [15:0]     r_yaw, w_yaw_d;
    logic            r_vld, w_vld_d;
    logic            w_int_s;
    logic            w_in_wait;
    logic            w_unused;

    assign w_unused = ^rd_data[15:8];

    int_sync u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (INT),
        .o_sync  (w_int_s)
    );

    assign w_in_wait = (r_state == CFG_WAIT) || (r_state == RD_WAIT);

    // Completion is registered so the next request follows done by one cycle;
    // the !r_done term stops a held done from being counted twice.
    always_comb begin
        w_done_d = done && w_in_wait && !r_done;
        w_byte_d = r_byte;
        if (w_done_d) begin
            w_byte_d = rd_data[7:0];
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        w_hold_d  = r_hold;

        case (r_state)
            PWR_UP: begin
                if (r_cnt == PWR_CNT) begin
                    w_state_d = CFG_ISSUE;
                    w_idx_d   = 3'd0;
                end else begin
                    w_cnt_d = r_cnt + 16'd1;
                end
            end
            CFG_ISSUE: w_state_d = CFG_WAIT;
            CFG_WAIT: begin
                if (r_done) begin
                    if (r_idx == CFG_LAST) begin
                        w_state_d = IDLE;
                    end else begin
                        w_idx_d   = r_idx + 3'd1;
                        w_state_d = CFG_ISSUE;
                    end
                end
            end
            IDLE: begin
                if (w_int_s) begin
                    w_state_d = RD_ISSUE;
                    w_idx_d   = 3'd0;
                end
            end
            RD_ISSUE: w_state_d = RD_WAIT;
            RD_WAIT: begin
                if (r_done) begin
                    for (int i = 0; i < int'(NUM_RD); i++) begin
                        if (r_idx == 3'(i)) begin
                            w_hold_d[i] = r_byte;
                        end
                    end
                    if (r_idx == RD_LAST) begin
                        w_state_d = VALID;
                    end else begin
                        w_idx_d   = r_idx + 3'd1;
                        w_state_d = RD_ISSUE;
                    end
                end
            end
            VALID:   w_state_d = IDLE;
            default: w_state_d = PWR_UP;
        endcase
    end

    // wrt and cmd are registered on the edge entering an ISSUE state, so wrt is
    // high exactly for the single ISSUE cycle.
    always_comb begin
        w_wrt_d  = 1'b0;
        w_cmd_d  = r_cmd;
        w_vld_d  = 1'b0;
        w_ptch_d = r_ptch;
        w_roll_d = r_roll;
        w_yaw_d  = r_yaw;

        if (w_state_d == CFG_ISSUE) begin
            w_wrt_d = 1'b1;
            w_cmd_d = cfg_word(w_idx_d);
        end else if (w_state_d == RD_ISSUE) begin
            w_wrt_d = 1'b1;
            w_cmd_d = {RD_BASE + {5'd0, w_idx_d}, 8'h00};
        end

        // Use the next holding bytes so the final byte lands in yaw this edge.
        if (w_state_d == VALID) begin
            w_vld_d  = 1'b1;
            w_ptch_d = {w_hold_d[1], w_hold_d[0]};
            w_roll_d = {w_hold_d[3], w_hold_d[2]};
            w_yaw_d  = {w_hold_d[5], w_hold_d[4]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PWR_UP;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_wrt   <= 1'b0;
            r_cmd   <= 16'h0000;
            r_hold  <= '0;
            r_done  <= 1'b0;
            r_byte  <= 8'h00;
            r_ptch  <= 16'h0000;
            r_roll  <= 16'h0000;
            r_yaw   <= 16'h0000;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_wrt   <= w_wrt_d;
            r_cmd   <= w_cmd_d;
            r_hold  <= w_hold_d;
            r_done  <= w_done_d;
            r_byte  <= w_byte_d;
            r_ptch  <= w_ptch_d;
            r_roll  <= w_roll_d;
            r_yaw   <= w_yaw_d;
            r_vld   <= w_vld_d;
        end
    end

    assign wrt  = r_wrt;
    assign cmd  = r_cmd;
    assign ptch = r_ptch;
    assign roll = r_roll;
    assign yaw  = r_yaw;
    assign vld  = r_vld;

endmodule

// File: tb/tb_inert_intf.sv
// Scoreboard bench for inert_intf with a model SPI master answering 40 clk
// after each request.
module tb_inert_intf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] ptch, roll, yaw;
    logic        vld;

    always #5 clk = ~clk;

    inert_intf #(.PWR_UP_CLKS(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .INT     (INT),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .ptch    (ptch),
        .roll    (roll),
        .yaw     (yaw),
        .vld     (vld)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_cmd_q[$];
    logic [47:0] exp_out_q[$];
    logic [47:0] prev_out = '0;
    logic        last_vld = 1'b0;
    logic [7:0]  rd_bytes[6];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_cfg();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1062);
        exp_cmd_q.push_back(16'h1162);
        exp_cmd_q.push_back(16'h1460);
    endtask

    task automatic push_reads(input int last);
        for (int i = 0; i <= last; i++) begin
            exp_cmd_q.push_back(16'hA200 + 16'(i * 256));
        end
    endtask

    task automatic push_out();
        exp_out_q.push_back({rd_bytes[1], rd_bytes[0], rd_bytes[3], rd_bytes[2],
                             rd_bytes[5], rd_bytes[4]});
    endtask

    // Counts rising edges until wrt is seen on a falling edge.
    task automatic wait_wrt(output int n, input int max);
        n = 0;
        while (n < max) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (wrt) return;
        end
        n = -1;
    endtask

    task automatic wait_vld(input string name, input int max);
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (vld) return;
        end
        n_chk++;
        n_err++;
        $display("FAIL %s: vld not seen within %0d cycles", name, max);
    endtask

    // Model SPI master.
    initial begin
        logic [15:0] c;
        int          a;
        logic        aborted;
        forever begin
            @(negedge clk);
            if (rst_n && wrt) begin
                c = cmd;
                aborted = 1'b0;
                for (int i = 0; i < 39; i++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (wrt) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL wrt_while_busy: got cmd %h while %h outstanding", cmd, c);
                    end
                end
                if (!aborted) begin
                    a = int'(c[15:8]) - 'hA2;
                    rd_data = (a >= 0 && a < 6) ? {8'hEE, rd_bytes[a]} : 16'h00FF;
                    done = 1'b1;
                    @(negedge clk);
                    done = 1'b0;
                    rd_data = 16'h0000;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents wrt or vld.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_out = '0;
                last_vld = 1'b0;
            end else begin
                if (wrt) begin
                    if (exp_cmd_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_wrt: got cmd %h with nothing expected", cmd);
                    end else begin
                        check("cmd", {32'h0, cmd}, {32'h0, exp_cmd_q.pop_front()});
                    end
                end
                if (vld) begin
                    check("vld_width", {47'h0, last_vld}, 48'h0);
                    if (exp_out_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_vld: got %h%h%h", ptch, roll, yaw);
                    end else begin
                        check("outputs", {ptch, roll, yaw}, exp_out_q.pop_front());
                    end
                    prev_out = {ptch, roll, yaw};
                end else if ({ptch, roll, yaw} !== prev_out) begin
                    check("hold_between_vld", {ptch, roll, yaw}, prev_out);
                    prev_out = {ptch, roll, yaw};
                end
                last_vld = vld;
            end
        end
    end

    initial begin
        int lat;
        for (int i = 0; i < 6; i++) rd_bytes[i] = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_wrt", {47'h0, wrt}, 48'h0);
        check("rst_cmd", {32'h0, cmd}, 48'h0);
        check("rst_vld", {47'h0, vld}, 48'h0);
        check("rst_out", {ptch, roll, yaw}, 48'h0);

        // Power-up and configuration; an INT pulse here must be ignored.
        push_cfg();
        rst_n = 1'b1;
        wait_wrt(lat, 60);
        check("pwrup_latency", 48'(lat), 48'd17);
        INT = 1'b1;
        repeat (3) @(negedge clk);
        INT = 1'b0;
        repeat (220) @(negedge clk);
        check("cfg_drained", 48'(exp_cmd_q.size()), 48'd0);

        // First read: 1234 / 5678 / 9ABC.
        rd_bytes = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        push_reads(5);
        push_out();
        INT = 1'b1;
        wait_wrt(lat, 10);
        check("int_latency", 48'(lat), 48'd3);
        check("first_rd_cmd", {32'h0, cmd}, 48'h00000000A200);
        INT = 1'b0;
        wait_vld("read1", 400);

        // Second read: ptch=8001; outputs must hold until vld.
        repeat (5) @(negedge clk);
        rd_bytes = '{8'h01, 8'h80, 8'h11, 8'h11, 8'h22, 8'h22};
        push_reads(5);
        push_out();
        INT = 1'b1;
        repeat (2) @(negedge clk);
        INT = 1'b0;
        wait_vld("read2", 400);
        check("read2_ptch", {32'h0, ptch}, 48'h8001);

        // Third read aborted by reset during the A5 transaction.
        repeat (5) @(negedge clk);
        rd_bytes = '{8'h0F, 8'h7E, 8'h33, 8'h44, 8'h55, 8'h66};
        push_reads(3);
        INT = 1'b1;
        repeat (2) @(negedge clk);
        INT = 1'b0;
        for (int k = 0; k < 4; k++) wait_wrt(lat, 80);
        check("a5_issued", {32'h0, cmd}, 48'h00000000A500);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wrt", {47'h0, wrt}, 48'h0);
        check("abort_cmd", {32'h0, cmd}, 48'h0);
        check("abort_out", {ptch, roll, yaw}, 48'h0);
        check("abort_q", 48'(exp_cmd_q.size()), 48'd0);

        // Restart with INT held high: config, then back-to-back reads.
        push_cfg();
        for (int k = 0; k < 3; k++) begin
            push_reads(5);
            push_out();
        end
        INT = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_vld("b2b_1", 1000);
        @(negedge clk);
        wait_vld("b2b_2", 400);
        INT = 1'b0;
        @(negedge clk);
        wait_vld("b2b_3", 400);
        repeat (100) @(negedge clk);
        check("cmd_q_empty", 48'(exp_cmd_q.size()), 48'd0);
        check("out_q_empty", 48'(exp_out_q.size()), 48'd0);
        check("final_yaw", {32'h0, yaw}, 48'h6655);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/inert_intf.md
INERT_INTF -- requirements
Module: inert_intf

Interface
REQ-001 Parameter: PWR_UP_CLKS, default 65535, number of clk cycles to wait after reset before IMU configuration starts.
REQ-002 clk  input  1  system clock; all flops rise-edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 INT  input  1  IMU data-ready interrupt, asynchronous to clk, active-high level.
REQ-005 wrt  output  1  one-cycle request to the SPI master to start a 16-bit transaction.
REQ-006 cmd  output  16  SPI command word; stable from wrt until the matching done.
REQ-007 done  input  1  one-cycle SPI transaction-complete pulse from the SPI master.
REQ-008 rd_data  input  16  SPI receive word; bits [7:0] hold the read byte, valid in the done cycle.
REQ-009 ptch, roll, yaw  output  16 each  latest signed sensor readings, {high byte, low byte}.
REQ-010 vld  output  1  one-cycle pulse when ptch, roll and yaw are updated.

Function
REQ-011 INT SHALL pass through a two-flop synchronizer; the FSM SHALL use only the second flop (INT_s).
REQ-012 FSM states SHALL be PWR_UP, CFG_ISSUE, CFG_WAIT, IDLE, RD_ISSUE, RD_WAIT and VALID.
REQ-013 PWR_UP: 16-bit counter increments from 0; when it reaches PWR_UP_CLKS, go to CFG_ISSUE with index=0.
REQ-014 Config writes, in order index 0..3: 16'h0D02, 16'h1062, 16'h1162, 16'h1460.
REQ-015 CFG_ISSUE/RD_ISSUE: wrt=1 and cmd loaded on the same edge; wrt is high for exactly one cycle; then go to the matching WAIT state.
REQ-016 CFG_WAIT on done: if index==3, go to IDLE; otherwise increment index and go to CFG_ISSUE.
REQ-017 IDLE: when INT_s==1, go to RD_ISSUE with index=0; INT_s is ignored in every other state.
REQ-018 Read commands: cmd = {8'hA2+index, 8'h00} for index 0..5, giving addresses A2..A7.
REQ-019 Read mapping: A2/A3 -> ptch low/high, A4/A5 -> roll low/high, A6/A7 -> yaw low/high.
REQ-020 RD_WAIT on done: capture rd_data[7:0] into the holding byte selected by index; if index==5, go to VALID; otherwise increment index and go to RD_ISSUE.
REQ-021 VALID: ptch, roll and yaw SHALL update together from the holding bytes on the edge entering VALID, vld=1 for that cycle only, then go to IDLE.
REQ-022 ptch, roll and yaw SHALL never show a partial update between vld pulses.
REQ-023 Latency: INT rising before edge N -> wrt high after edge N+2.
REQ-024 Latency: done sampled at edge K -> next wrt high after edge K+1.
REQ-025 done received outside a WAIT state SHALL be ignored; wrt SHALL never be asserted while a transaction is outstanding.
REQ-026 INT held high after VALID SHALL start a new read sequence immediately from IDLE; there is no queuing of INT edges.

Reset
REQ-027 Reset SHALL force: state=PWR_UP, counter=0, index=0, wrt=0, cmd=16'h0000, ptch/roll/yaw=0, holding bytes=0, vld=0, synchronizer flops=0.
REQ-028 Reset asserted mid-transaction SHALL abort it; after release, the full power-up and configuration sequence SHALL repeat.

Structure
REQ-029 Package inert_pkg SHALL hold the state enum, the four config words, the read base address 8'hA2, and the final indices (3, 5).
REQ-030 The synchronizer SHALL be a sub-module, int_sync (2-flop, reset to 0); everything else SHALL be in one module.

Verification
REQ-031 Bench SHALL use PWR_UP_CLKS=16 and a model SPI master returning done 40 clk after each wrt.
REQ-032 Reset release -> first wrt after about 17 clk with cmd=0D02; then 1062, 1162, 1460; no further wrt while INT=0.
REQ-033 Reads returning bytes 34,12,78,56,BC,9A for A2..A7 -> one vld pulse with ptch=1234, roll=5678, yaw=9ABC.
REQ-034 INT pulsed during configuration -> ignored, no read until INT rises in IDLE; INT rising before edge N -> wrt after edge N+2, cmd=A200.
REQ-035 Read returning ptch=8001 -> outputs hold previous values until the vld cycle, then all three change on the same edge.
REQ-036 rst_n asserted during the A5 read -> wrt=0, outputs=0; after release the sequence restarts from 0D02; INT held high -> back-to-back read sequences.
